// File: rtl/contour_tracer.sv
// contour_tracer: follows an 8-connected edge contour from a seed pixel, reading an
// edge map with fixed read latency and writing a bin label for every traced pixel.
module contour_tracer #(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned BIN_W     = 3,
  parameter int unsigned EDGE_W    = 3,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned MAX_STEPS = 4095
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [9:0]        x_start,
  input  logic [8:0]        y_start,
  input  logic [CNT_W-1:0]  pixels_per_bin,
  input  logic [BIN_W-1:0]  num_bins,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [EDGE_W-1:0] edge_in,
  output logic              wr_en,
  output logic [BIN_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [CNT_W-1:0]  pixel_count
);

  typedef enum logic [2:0] {StIdle, StWrite, StIssue, StWait, StCheck, StFin} state_e;

  localparam logic [1:0] StatClosed  = 2'd0;
  localparam logic [1:0] StatOpen    = 2'd1;
  localparam logic [1:0] StatTimeout = 2'd2;
  localparam logic [1:0] StatBad     = 2'd3;

  state_e           r_state, w_state_next;
  logic [9:0]       r_cur_x, r_prev_x, r_start_x;
  logic [8:0]       r_cur_y, r_prev_y, r_start_y;
  logic             r_has_prev;
  logic [2:0]       r_dir, r_tried, r_wait;
  logic [CNT_W-1:0] r_ppb, r_bin_cnt, r_pixel_count;
  logic [BIN_W-1:0] r_nbins, r_bin;
  logic [1:0]       r_status;

  logic [11:0]      w_dx, w_dy, w_nx, w_ny;
  logic             w_nb_in, w_nb_prev, w_nb_ok, w_nb_is_start, w_bad_start;
  logic [ADDR_W-1:0] w_addr_cur, w_addr_nb;
  logic [CNT_W-1:0] w_cnt_inc, w_ppb_eff;
  logic [BIN_W-1:0] w_nb_eff;
  logic             w_accept, w_adv, w_move, w_set_status;
  logic [1:0]       w_status_val;

  // Neighbour offset for the current search direction (0=R, clockwise).
  always_comb begin
    w_dx = 12'd0;
    w_dy = 12'd0;
    unique case (r_dir)
      3'd0: w_dx = 12'd1;
      3'd1: begin w_dx = 12'd1;   w_dy = 12'd1;   end
      3'd2: w_dy = 12'd1;
      3'd3: begin w_dx = 12'hFFF; w_dy = 12'd1;   end
      3'd4: w_dx = 12'hFFF;
      3'd5: begin w_dx = 12'hFFF; w_dy = 12'hFFF; end
      3'd6: w_dy = 12'hFFF;
      3'd7: begin w_dx = 12'd1;   w_dy = 12'hFFF; end
      default: ;
    endcase
  end

  // A step off the left/top edge wraps to 0xFFF and fails the bound check.
  assign w_nx          = {2'b00, r_cur_x} + w_dx;
  assign w_ny          = {3'b000, r_cur_y} + w_dy;
  assign w_nb_in       = (32'(w_nx) < IMG_W) && (32'(w_ny) < IMG_H);
  assign w_nb_prev     = r_has_prev && (w_nx[9:0] == r_prev_x) && (w_ny[8:0] == r_prev_y);
  assign w_nb_ok       = w_nb_in && !w_nb_prev;
  assign w_nb_is_start = (w_nx[9:0] == r_start_x) && (w_ny[8:0] == r_start_y);
  assign w_bad_start   = (32'(x_start) >= IMG_W) || (32'(y_start) >= IMG_H);
  assign w_addr_cur    = ADDR_W'(32'(r_cur_y) * IMG_W + 32'(r_cur_x));
  assign w_addr_nb     = ADDR_W'(32'(w_ny[8:0]) * IMG_W + 32'(w_nx[9:0]));
  assign w_cnt_inc     = r_pixel_count + CNT_W'(1);
  assign w_ppb_eff     = (r_ppb == '0) ? CNT_W'(1) : r_ppb;
  assign w_nb_eff      = (r_nbins == '0) ? BIN_W'(1) : r_nbins;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_adv        = 1'b0;
    w_move       = 1'b0;
    w_set_status = 1'b0;
    w_status_val = StatClosed;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_bad_start) begin
            w_state_next = StFin;
            w_set_status = 1'b1;
            w_status_val = StatBad;
          end else begin
            w_state_next = StWrite;
          end
        end
      end
      StWrite: begin
        if (w_cnt_inc == CNT_W'(MAX_STEPS)) begin
          w_state_next = StFin;
          w_set_status = 1'b1;
          w_status_val = StatTimeout;
        end else begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (!w_nb_ok) begin
          w_adv = 1'b1;
          if (r_tried == 3'd7) begin
            w_state_next = StFin;
            w_set_status = 1'b1;
            w_status_val = StatOpen;
          end
        end else if (MEM_LAT <= 1) begin
          w_state_next = StCheck;
        end else begin
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (r_wait == 3'(MEM_LAT - 2)) w_state_next = StCheck;
      end
      StCheck: begin
        if (edge_in != '0) begin
          if (w_nb_is_start) begin
            w_state_next = StFin;
            w_set_status = 1'b1;
            w_status_val = StatClosed;
          end else begin
            w_move       = 1'b1;
            w_state_next = StWrite;
          end
        end else begin
          w_adv = 1'b1;
          if (r_tried == 3'd7) begin
            w_state_next = StFin;
            w_set_status = 1'b1;
            w_status_val = StatOpen;
          end else begin
            w_state_next = StIssue;
          end
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Trace datapath: position, search direction, bin labelling and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_prev_x      <= '0;
      r_prev_y      <= '0;
      r_start_x     <= '0;
      r_start_y     <= '0;
      r_has_prev    <= 1'b0;
      r_dir         <= '0;
      r_tried       <= '0;
      r_wait        <= '0;
      r_ppb         <= '0;
      r_nbins       <= '0;
      r_bin         <= BIN_W'(1);
      r_bin_cnt     <= '0;
      r_pixel_count <= '0;
      r_status      <= StatClosed;
    end else begin
      if (w_accept) begin
        r_start_x     <= x_start;
        r_start_y     <= y_start;
        r_cur_x       <= x_start;
        r_cur_y       <= y_start;
        r_has_prev    <= 1'b0;
        r_ppb         <= pixels_per_bin;
        r_nbins       <= num_bins;
        r_bin         <= BIN_W'(1);
        r_bin_cnt     <= '0;
        r_pixel_count <= '0;
        r_status      <= StatClosed;
      end
      if (r_state == StWrite) begin
        r_pixel_count <= w_cnt_inc;
        if (r_bin_cnt + CNT_W'(1) >= w_ppb_eff) begin
          r_bin_cnt <= '0;
          if (r_bin < w_nb_eff) r_bin <= r_bin + BIN_W'(1);
        end else begin
          r_bin_cnt <= r_bin_cnt + CNT_W'(1);
        end
        // Resume just past the pixel we came from: (d+5) mod 8 via 3-bit wrap.
        r_dir   <= r_has_prev ? r_dir + 3'd5 : 3'd0;
        r_tried <= '0;
      end
      if (w_adv) begin
        r_dir   <= r_dir + 3'd1;
        r_tried <= r_tried + 3'd1;
      end
      if (r_state == StIssue)     r_wait <= '0;
      else if (r_state == StWait) r_wait <= r_wait + 3'd1;
      if (w_move) begin
        r_prev_x   <= r_cur_x;
        r_prev_y   <= r_cur_y;
        r_cur_x    <= w_nx[9:0];
        r_cur_y    <= w_ny[8:0];
        r_has_prev <= 1'b1;
      end
      if (w_set_status) r_status <= w_status_val;
    end
  end

  // Outputs; an invalid neighbour never reaches mem_addr (current pixel shown instead).
  always_comb begin
    mem_addr = '0;
    wr_en    = 1'b0;
    wr_data  = '0;
    done     = 1'b0;
    busy     = (r_state != StIdle);
    unique case (r_state)
      StWrite: begin
        mem_addr = w_addr_cur;
        wr_en    = 1'b1;
        wr_data  = r_bin;
      end
      StIssue, StWait, StCheck: mem_addr = w_nb_ok ? w_addr_nb : w_addr_cur;
      StFin:   done = 1'b1;
      default: ;
    endcase
  end

  assign status      = r_status;
  assign pixel_count = r_pixel_count;

endmodule

// File: tb/tb_contour_tracer.sv
// tb_contour_tracer: table-driven and randomized checks of contour_tracer on an 8x8 image
// against a direct trace model; three instances differ only in MAX_STEPS.
module tb_contour_tracer;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start [3];
  logic [9:0]  x_start;
  logic [8:0]  y_start;
  logic [11:0] ppb;
  logic [2:0]  nbins;
  logic [AW-1:0] mem_addr [3];
  logic        wr_en [3];
  logic [2:0]  wr_data [3];
  logic        busy [3];
  logic        done [3];
  logic [1:0]  status [3];
  logic [11:0] pcount [3];
  logic [2:0]  p0 [3];
  logic [2:0]  p1 [3];
  logic [2:0]  img [64];

  contour_tracer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MEM_LAT(2), .MAX_STEPS(4095)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .x_start(x_start), .y_start(y_start),
    .pixels_per_bin(ppb), .num_bins(nbins), .mem_addr(mem_addr[0]), .edge_in(p1[0]),
    .wr_en(wr_en[0]), .wr_data(wr_data[0]), .busy(busy[0]), .done(done[0]),
    .status(status[0]), .pixel_count(pcount[0]));

  contour_tracer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MEM_LAT(2), .MAX_STEPS(4)) u_to4 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .x_start(x_start), .y_start(y_start),
    .pixels_per_bin(ppb), .num_bins(nbins), .mem_addr(mem_addr[1]), .edge_in(p1[1]),
    .wr_en(wr_en[1]), .wr_data(wr_data[1]), .busy(busy[1]), .done(done[1]),
    .status(status[1]), .pixel_count(pcount[1]));

  contour_tracer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MEM_LAT(2), .MAX_STEPS(40)) u_to40 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .x_start(x_start), .y_start(y_start),
    .pixels_per_bin(ppb), .num_bins(nbins), .mem_addr(mem_addr[2]), .edge_in(p1[2]),
    .wr_en(wr_en[2]), .wr_data(wr_data[2]), .busy(busy[2]), .done(done[2]),
    .status(status[2]), .pixel_count(pcount[2]));

  // Edge-map memory with a two-cycle read pipeline per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      p0[i] <= (mem_addr[i] < AW'(64)) ? img[mem_addr[i][5:0]] : 3'd0;
      p1[i] <= p0[i];
    end
  end

  // Monitor of the selected instance: writes, probed addresses, out-of-range addresses.
  int sel = 0;
  int q_addr[$];
  int q_data[$];
  int q_pr[$];
  int oor_cnt = 0;
  always @(negedge clk) begin
    if (wr_en[sel]) begin
      q_addr.push_back(int'(mem_addr[sel]));
      q_data.push_back(int'(wr_data[sel]));
    end
    if (mem_addr[sel] >= AW'(64)) oor_cnt <= oor_cnt + 1;
    if (busy[sel] && !wr_en[sel] && !done[sel]) q_pr.push_back(int'(mem_addr[sel]));
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference trace model: direct walk over the image array.
  int DX[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int DY[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int m_addr[$];
  int m_bin[$];
  int m_status;
  int m_count;

  task automatic run_model(input int sx, input int sy, input int p, input int nb,
                           input int maxs);
    int cx, cy, px, py, hp, dir, cnt, pe, ne, nx, ny, fd, bn;
    bit found, fin;
    m_addr.delete();
    m_bin.delete();
    m_count = 0;
    if (sx >= W || sy >= H) begin
      m_status = 3;
      return;
    end
    pe = (p == 0) ? 1 : p;
    ne = (nb == 0) ? 1 : nb;
    cx = sx; cy = sy; px = 0; py = 0; hp = 0; dir = 0; cnt = 0; fin = 0;
    while (!fin) begin
      bn = 1 + cnt / pe;
      m_addr.push_back(cy * W + cx);
      m_bin.push_back((bn < ne) ? bn : ne);
      cnt++;
      if (cnt == maxs) begin
        m_status = 2;
        fin = 1;
      end else begin
        found = 0; fd = 0; nx = 0; ny = 0;
        for (int k = 0; k < 8 && !found; k++) begin
          int d, tx, ty;
          d  = (dir + k) % 8;
          tx = cx + DX[d];
          ty = cy + DY[d];
          if (tx >= 0 && tx < W && ty >= 0 && ty < H && !(hp != 0 && tx == px && ty == py)
              && img[ty * W + tx] != 3'd0) begin
            found = 1; fd = d; nx = tx; ny = ty;
          end
        end
        if (!found) begin
          m_status = 1;
          fin = 1;
        end else if (nx == sx && ny == sy) begin
          m_status = 0;
          fin = 1;
        end else begin
          px = cx; py = cy; hp = 1; cx = nx; cy = ny; dir = (fd + 5) % 8;
        end
      end
    end
    m_count = cnt;
  endtask

  task automatic load_img(input int which);
    for (int k = 0; k < 64; k++) img[k] = 3'd0;
    case (which)
      0: begin  // ring around (3,3), mixed nonzero values
        img[2*W+2] = 3'd1; img[2*W+3] = 3'd2; img[2*W+4] = 3'd4; img[3*W+4] = 3'd1;
        img[4*W+4] = 3'd2; img[4*W+3] = 3'd4; img[4*W+2] = 3'd1; img[3*W+2] = 3'd2;
      end
      1: img[5*W+5] = 3'd7;
      2: begin
        img[0] = 3'd2; img[1] = 3'd2; img[2] = 3'd2; img[3] = 3'd2;
      end
      default: ;
    endcase
  endtask

  int w_base;

  // Launch one trace and check it; est/ecnt/eprb < 0 mean "take from model only".
  task automatic run_trace(input int inst, input int sx, input int sy, input int p,
                           input int nb, input int maxs, input int est, input int ecnt,
                           input int eprb, input bit interf, input bit rel_reset);
    int pb, ob, nw;
    bit got;
    logic [63:0] mask;
    sel = inst;
    @(negedge clk);
    #1;
    w_base = q_addr.size();
    pb = q_pr.size();
    ob = oor_cnt;
    x_start = 10'(sx); y_start = 9'(sy); ppb = 12'(p); nbins = 3'(nb);
    if (rel_reset) reset_n = 1'b1;
    start[inst] = 1'b1;
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
    if (est != 3) chk("busy_after_start", int'(busy[inst]), 1);
    if (interf) begin
      x_start = 10'd5; y_start = 9'd5; ppb = 12'd1; nbins = 3'd1;
    end
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (interf && c == 6) start[inst] = 1'b1;
      if (interf && c == 7) start[inst] = 1'b0;
      if (done[inst]) got = 1;
    end
    start[inst] = 1'b0;
    chk("done_seen", int'(got), 1);
    if (!got) return;
    #1;
    run_model(sx, sy, p, nb, maxs);
    if (est >= 0) chk("status_table", int'(status[inst]), est);
    if (ecnt >= 0) chk("count_table", int'(pcount[inst]), ecnt);
    chk("status_model", int'(status[inst]), m_status);
    chk("count_model", int'(pcount[inst]), m_count);
    nw = q_addr.size() - w_base;
    chk("n_writes", nw, m_addr.size());
    for (int k = 0; k < nw && k < m_addr.size(); k++) begin
      chk("wr_addr", q_addr[w_base + k], m_addr[k]);
      chk("wr_data", q_data[w_base + k], m_bin[k]);
    end
    chk("addr_in_range", oor_cnt - ob, 0);
    if (eprb >= 0) begin
      mask = '0;
      for (int k = pb; k < q_pr.size(); k++) mask[q_pr[k][5:0]] = 1'b1;
      chk("probe_count", $countones(mask), eprb);
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy[inst]), 0);
    chk("status_hold", int'(status[inst]), m_status);
  endtask

  typedef struct {
    int inst; int im; int sx; int sy; int p; int nb; int maxs;
    int est; int ecnt; int eprb; bit interf;
  } vec_t;

  vec_t vt[9];
  int ring_bins[8] = '{1, 1, 1, 2, 2, 2, 3, 3};
  bit got_w;

  initial begin
    vt[0] = '{0, 0, 2, 2, 3, 7, 4095, 0, 8, -1, 1'b0};  // closed ring
    vt[1] = '{0, 1, 5, 5, 1, 7, 4095, 1, 1,  8, 1'b0};  // isolated pixel
    vt[2] = '{0, 2, 0, 0, 2, 7, 4095, 1, 4, -1, 1'b0};  // corner line
    vt[3] = '{1, 0, 2, 2, 3, 7, 4,    2, 4, -1, 1'b0};  // timeout
    vt[4] = '{0, 0, 9, 2, 3, 7, 4095, 3, 0, -1, 1'b0};  // bad x
    vt[5] = '{0, 0, 2, 8, 3, 7, 4095, 3, 0, -1, 1'b0};  // bad y
    vt[6] = '{0, 0, 2, 2, 0, 0, 4095, 0, 8, -1, 1'b0};  // zero ppb / num_bins
    vt[7] = '{0, 0, 4, 4, 1, 2, 4095, 0, 8, -1, 1'b0};  // ring from another seed
    vt[8] = '{0, 0, 2, 2, 3, 7, 4095, 0, 8, -1, 1'b1};  // input changes + start while busy

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    x_start = '0; y_start = '0; ppb = '0; nbins = '0;
    load_img(0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_wr_en", int'(wr_en[0]), 0);
    chk("rst_mem_addr", int'(mem_addr[0]), 0);
    chk("rst_wr_data", int'(wr_data[0]), 0);
    chk("rst_status", int'(status[0]), 0);
    chk("rst_count", int'(pcount[0]), 0);

    // First start on the first rising edge after reset release.
    run_trace(0, 2, 2, 3, 7, 4095, 0, 8, -1, 1'b0, 1'b1);

    for (int v = 0; v < 9; v++) begin
      load_img(vt[v].im);
      run_trace(vt[v].inst, vt[v].sx, vt[v].sy, vt[v].p, vt[v].nb, vt[v].maxs,
                vt[v].est, vt[v].ecnt, vt[v].eprb, vt[v].interf, 1'b0);
      if (v == 0 && q_addr.size() - w_base == 8)
        for (int k = 0; k < 8; k++) chk("ring_bin", q_data[w_base + k], ring_bins[k]);
    end

    // Reset in the middle of a trace, during a write cycle.
    load_img(0);
    sel = 0;
    @(negedge clk);
    x_start = 10'd2; y_start = 9'd2; ppb = 12'd3; nbins = 3'd7;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    got_w = 0;
    for (int c = 0; c < 300 && !got_w; c++) begin
      @(negedge clk);
      if (wr_en[0] && pcount[0] >= 12'd2) got_w = 1;
    end
    chk("mid_write_seen", int'(got_w), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(wr_en[0]), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_mem_addr", int'(mem_addr[0]), 0);
    chk("mid_rst_wr_data", int'(wr_data[0]), 0);
    chk("mid_rst_count", int'(pcount[0]), 0);
    repeat (2) @(negedge clk);
    run_trace(0, 2, 2, 3, 7, 4095, 0, 8, -1, 1'b0, 1'b1);
    chk("post_rst_first_bin", q_data[w_base], 1);

    // Randomized images and seeds on the MAX_STEPS=40 instance.
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 64; k++)
        img[k] = ($urandom_range(0, 99) < 35) ? 3'($urandom_range(1, 7)) : 3'd0;
      run_trace(2, int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 7)), 40,
                -1, -1, -1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/contour_tracer.md
CONTOUR_TRACER -- requirements
Module: contour_tracer

Interface
REQ-001 SHALL have parameter IMG_W, default 640, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-buffer address width; address = y*IMG_W + x.
REQ-004 SHALL have parameter BIN_W, default 3, bin label width.
REQ-005 SHALL have parameter EDGE_W, default 3, edge-map data width.
REQ-006 SHALL have parameter MEM_LAT, default 2, read latency in cycles, range 1..7.
REQ-007 SHALL have parameter CNT_W, default 12, pixel counter width.
REQ-008 SHALL have parameter MAX_STEPS, default 4095, timeout on traced pixels.
REQ-009 SHALL have ports, one per line:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle trace request; ignored while busy
- x_start  in  10  start pixel column
- y_start  in  9  start pixel row
- pixels_per_bin  in  CNT_W  pixels labelled per bin, 0 treated as 1
- num_bins  in  BIN_W  highest bin label, saturation value
- mem_addr  out  ADDR_W  frame-buffer address
- edge_in  in  EDGE_W  edge value at mem_addr, MEM_LAT cycles later
- wr_en  out  1  write strobe to label buffer
- wr_data  out  BIN_W  bin label written at mem_addr
- busy  out  1  trace in progress
- done  out  1  one-cycle completion pulse
- status  out  2  0 CLOSED, 1 OPEN, 2 TIMEOUT, 3 BAD_START
- pixel_count  out  CNT_W  pixels labelled in last/current trace

Function
REQ-010 SHALL latch x_start, y_start, pixels_per_bin, num_bins on accepted start; later input changes have no effect.
REQ-011 SHALL use states IDLE, WRITE, ISSUE, WAIT, CHECK, FIN.
REQ-012 IDLE + start: if x_start>=IMG_W or y_start>=IMG_H -> FIN with status BAD_START, no memory access; else WRITE of start pixel.
REQ-013 WRITE: one cycle, wr_en=1, mem_addr=current pixel, wr_data=current bin; pixel_count increments; then ISSUE with search dir set.
REQ-014 Directions 0..7 = R, DR, D, DL, L, UL, U, UR (clockwise); start pixel search begins at dir 0; after a move in dir d, search begins at (d+5) mod 8.
REQ-015 ISSUE: neighbour outside 0..IMG_W-1 / 0..IMG_H-1 or equal to previous pixel is skipped same cycle (next dir, no mem access); otherwise mem_addr=neighbour, then WAIT MEM_LAT-1 cycles, then CHECK samples edge_in.
REQ-016 CHECK: edge_in!=0 and neighbour==start -> FIN, CLOSED, no write; edge_in!=0 otherwise -> previous<=current, current<=neighbour, WRITE; edge_in==0 -> next dir, ISSUE.
REQ-017 Eight directions examined (skipped ones counted) with no hit -> FIN, OPEN.
REQ-018 pixel_count==MAX_STEPS after a WRITE -> FIN, TIMEOUT, before further reads.
REQ-019 Bin: starts at 1; after pixels_per_bin writes in current bin, increments; saturates at num_bins (num_bins 0 treated as 1).
REQ-020 FIN: done=1 one cycle, busy=0, wr_en=0, -> IDLE; status and pixel_count hold until next accepted start.
REQ-021 busy=1 from cycle after accepted start through FIN inclusive; wr_en=1 only in WRITE.
REQ-022 mem_addr SHALL never exceed IMG_W*IMG_H-1.

Reset
REQ-023 reset_n low SHALL immediately force IDLE, busy=0, done=0, wr_en=0, mem_addr=0, wr_data=0, status=0, pixel_count=0, bin=1, at any point including mid-trace.
REQ-024 First start accepted on first rising edge after reset_n deasserts.

Verification (IMG_W=IMG_H=8, MEM_LAT=2)
REQ-025 Ring of 8 edge pixels around (3,3), start (2,2), pixels_per_bin=3, num_bins=7 -> 8 writes, wr_data 1,1,1,2,2,2,3,3, status CLOSED, pixel_count=8.
REQ-026 Isolated edge pixel at (5,5) -> 1 write, 8 probes, status OPEN, pixel_count=1.
REQ-027 Start (0,0), horizontal line to (3,0) -> no mem_addr out of range, 4 writes, OPEN.
REQ-028 Ring case with MAX_STEPS=4 -> status TIMEOUT, pixel_count=4; x_start=9 -> BAD_START, zero writes.
REQ-029 reset_n low mid-trace -> wr_en=0, busy=0 same cycle; next start traces correctly from bin 1; start while busy ignored.
